// File: rtl/gemm_operand_loader_if.sv
// Operand-loader bus: word-serial input stream with valid/ready, control
// strobes, and the parallel scalar/matrix banks presented to the GEMM core.
interface gemm_operand_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int MATRIX_WIDTH  = 4,
  parameter int MATRIX_HEIGHT = 4
);
  localparam int TOTAL = 2 + 3 * MATRIX_HEIGHT * MATRIX_WIDTH;
  localparam int PTR_W = $clog2(TOTAL);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  abort;
  logic                  mat_ack;
  logic                  mat_valid;
  logic [PTR_W-1:0]      load_ptr;
  logic [DATA_WIDTH-1:0] alpha;
  logic [DATA_WIDTH-1:0] beta;
  logic [DATA_WIDTH-1:0] a_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic [DATA_WIDTH-1:0] b_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic [DATA_WIDTH-1:0] c_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];

  // Producer / consumer side (drives the stream and the control strobes)
  modport master (
    output in_valid, in_data, abort, mat_ack,
    input  in_ready, mat_valid, load_ptr, alpha, beta, a_matrix, b_matrix, c_matrix
  );

  // Loader side
  modport slave (
    input  in_valid, in_data, abort, mat_ack,
    output in_ready, mat_valid, load_ptr, alpha, beta, a_matrix, b_matrix, c_matrix
  );
endinterface

// File: rtl/gemm_operand_loader.sv
// GEMM operand loader: collects alpha, beta, A, B, C from a word-serial
// stream into register banks, presents them with mat_valid and holds them
// frozen until the compute block acknowledges with mat_ack.
module gemm_operand_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int MATRIX_WIDTH  = 4,
  parameter int MATRIX_HEIGHT = 4
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  gemm_operand_loader_if.slave  bus
);
  localparam int ELEMS = MATRIX_HEIGHT * MATRIX_WIDTH;
  localparam int TOTAL = 2 + 3 * ELEMS;
  localparam int PTR_W = $clog2(TOTAL);
  localparam int ROW_W = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
  localparam int COL_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

  // Stream slot map: 0 alpha, 1 beta, then A, B, C each row-major
  localparam logic [PTR_W-1:0] ALPHA_P = PTR_W'(0);
  localparam logic [PTR_W-1:0] BETA_P  = PTR_W'(1);
  localparam logic [PTR_W-1:0] A_BASE  = PTR_W'(2);
  localparam logic [PTR_W-1:0] B_BASE  = PTR_W'(2 + ELEMS);
  localparam logic [PTR_W-1:0] C_BASE  = PTR_W'(2 + 2 * ELEMS);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(TOTAL - 1);
  localparam logic [PTR_W-1:0] MW_P    = PTR_W'(MATRIX_WIDTH);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] alpha_q, alpha_d;
  logic [DATA_WIDTH-1:0] beta_q, beta_d;
  logic [DATA_WIDTH-1:0] a_q [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic [DATA_WIDTH-1:0] a_d [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic [DATA_WIDTH-1:0] b_q [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic [DATA_WIDTH-1:0] b_d [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic [DATA_WIDTH-1:0] c_q [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic [DATA_WIDTH-1:0] c_d [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];

  logic [PTR_W-1:0]      idx_s;
  logic [ROW_W-1:0]      row_s;
  logic [COL_W-1:0]      col_s;

  // Decode load_ptr into an element offset and row/column within its matrix
  always_comb begin
    idx_s = {PTR_W{1'b0}};
    if (ptr_q >= C_BASE) begin
      idx_s = ptr_q - C_BASE;
    end else if (ptr_q >= B_BASE) begin
      idx_s = ptr_q - B_BASE;
    end else if (ptr_q >= A_BASE) begin
      idx_s = ptr_q - A_BASE;
    end else begin
      idx_s = {PTR_W{1'b0}};
    end
    row_s = ROW_W'(idx_s / MW_P);
    col_s = COL_W'(idx_s % MW_P);
  end

  // Next-state, pointer and bank-write logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    if (bus.abort) begin
      state_d = ST_LOAD;
      ptr_d   = {PTR_W{1'b0}};
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.in_valid) begin
            if (ptr_q == ALPHA_P) begin
              alpha_d = bus.in_data;
            end else if (ptr_q == BETA_P) begin
              beta_d = bus.in_data;
            end else if (ptr_q < B_BASE) begin
              a_d[row_s][col_s] = bus.in_data;
            end else if (ptr_q < C_BASE) begin
              b_d[row_s][col_s] = bus.in_data;
            end else begin
              c_d[row_s][col_s] = bus.in_data;
            end
            if (ptr_q == LAST_P) begin
              state_d = ST_FULL;
              ptr_d   = {PTR_W{1'b0}};
            end else begin
              ptr_d = ptr_q + PTR_W'(1);
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_FULL: begin
          if (bus.mat_ack) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_LOAD;
          ptr_d   = {PTR_W{1'b0}};
        end
      endcase
    end
  end

  // State, pointer and bank registers; reset clears everything asynchronously
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= ST_LOAD;
      ptr_q   <= {PTR_W{1'b0}};
      alpha_q <= {DATA_WIDTH{1'b0}};
      beta_q  <= {DATA_WIDTH{1'b0}};
      for (int r = 0; r < MATRIX_HEIGHT; r++) begin
        for (int c = 0; c < MATRIX_WIDTH; c++) begin
          a_q[r][c] <= {DATA_WIDTH{1'b0}};
          b_q[r][c] <= {DATA_WIDTH{1'b0}};
          c_q[r][c] <= {DATA_WIDTH{1'b0}};
        end
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  // Outputs come straight from registers; handshake flags decode the state flop
  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.mat_valid = (state_q == ST_FULL);
  assign bus.load_ptr  = ptr_q;
  assign bus.alpha     = alpha_q;
  assign bus.beta      = beta_q;
  assign bus.a_matrix  = a_q;
  assign bus.b_matrix  = b_q;
  assign bus.c_matrix  = c_q;

endmodule
